// File: rtl/dmux_pkg.sv
// Shared types and sizing for the 8-way 16-bit demultiplexing collector.
package dmux_pkg;
  typedef enum logic {FILL, HOLD} collector_state_t;
  localparam int LANES   = 8;
  localparam int INDEX_W = 3;
endpackage

// File: rtl/register_16.sv
// WIDTH-bit lane register with load enable and asynchronous active-low reset.
module register_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;
endmodule

// File: rtl/dmux_8_way_16_collector.sv
// Collects eight serialized words into lanes a..h and releases them as one
// parallel frame over a valid/ready handshake.
module dmux_8_way_16_collector
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   e,
  output logic [WIDTH-1:0]   f,
  output logic [WIDTH-1:0]   g,
  output logic [WIDTH-1:0]   h,
  output logic [INDEX_W-1:0] index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
);
  collector_state_t   state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               overrun_q, overrun_d;
  logic               accept;
  logic [LANES-1:0]   lane_we;
  logic [WIDTH-1:0]   lane_q [LANES];

  // Inverse of the transmitter's 3-bit mux select.
  function automatic logic [LANES-1:0] decode_onehot(input logic [INDEX_W-1:0] sel);
    decode_onehot      = '0;
    decode_onehot[sel] = 1'b1;
  endfunction

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready && !clear;
  assign lane_we   = accept ? decode_onehot(index_q) : '0;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    overrun_d = overrun_q;
    if (clear) begin
      state_d   = FILL;
      index_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            index_d = index_q + INDEX_W'(1);
            if (index_q == INDEX_W'(LANES - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      index_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    register_16 #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (lane_we[k]),
      .d_i   (in),
      .q_o   (lane_q[k])
    );
  end

  assign a       = lane_q[0];
  assign b       = lane_q[1];
  assign c       = lane_q[2];
  assign d       = lane_q[3];
  assign e       = lane_q[4];
  assign f       = lane_q[5];
  assign g       = lane_q[6];
  assign h       = lane_q[7];
  assign index   = index_q;
  assign overrun = overrun_q;
endmodule

// File: doc/dmux_8_way_16_collector.md
# dmux_8_way_16_collector

Sequential 1-to-8 demultiplexing collector: accepts a stream of 16-bit words over a valid/ready handshake and steers each word into one of eight lane registers a..h in order. After lane h is written, it presents the complete 8-word frame on a second valid/ready handshake. It is the receiving end of a link whose transmitter uses an 8-way 16-bit mux with a 3-bit select to serialize eight words. It sits between that serializer and any consumer that needs all eight words in parallel.

## Interface
- WIDTH, 16, data width of every word and lane
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous frame abort; takes priority over all handshakes
- in  input  WIDTH  incoming word
- in_valid  input  1  in carries a word
- in_ready  output  1  collector can accept a word this cycle
- a, b, c, d, e, f, g, h  output  WIDTH each  lane registers 0..7
- index  output  3  lane the next accepted word will be written to
- out_valid  output  1  a..h hold a complete frame
- out_ready  input  1  consumer takes the frame this cycle
- overrun  output  1  sticky flag: in_valid seen while in_ready low

## Operation
- Two states, FILL and HOLD. Reset state is FILL.
- Reset values: index=0, every lane=0, out_valid=0, in_ready=1, overrun=0.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid, the word is written to lane[index] (0→a … 7→h) and index increments.
  - Accepting with index=7 writes h, wraps index to 0, and moves to HOLD.
- HOLD:
  - in_ready=0, out_valid=1. Lanes are frozen.
  - On out_ready, move to FILL. Lanes keep their values until they are overwritten lane by lane.
- Lanes not yet rewritten in the current frame keep their previous-frame values. Consumers sample only while out_valid=1.
- clear:
  - index←0, state←FILL, out_valid←0.
  - Lanes are not zeroed.
  - A word presented in the same cycle as clear is dropped.
  - overrun←0.
- overrun: set on any cycle with in_valid=1 and in_ready=0 (HOLD). It stays set until clear or reset.
- Simultaneous out_ready and in_valid in HOLD: the frame is released, the word is not accepted, and overrun is set. This is a transmitter protocol violation.
- Reset asserted mid-frame or in HOLD: all outputs return immediately (asynchronously) to their reset values. The partial frame is lost.

## Timing
- in_ready and out_valid are decoded only from the registered state, with no combinational path from in_valid or out_ready.
- A word accepted at edge N is visible on its lane output after edge N.
- Minimum frame latency: 8 cycles from the first accept to out_valid=1, which follows the edge that writes h.
- out_valid falls on the edge where out_ready is sampled high. in_ready rises on that same edge, so there is one bubble cycle per frame.
- Peak throughput: 8 words per 9 cycles when out_ready is held high.
- index and every lane change only on rising clk edges, except for asynchronous reset.

## Structure
- The package dmux_pkg holds:
  - typedef enum logic {FILL, HOLD} collector_state_t
  - localparam LANES = 8
  - localparam INDEX_W = 3
- Natural sub-module: register_16, a WIDTH-bit register with load enable and async active-low reset. Eight instances are used; the load enable of lane k is (accept && index==k).
- The top level holds the FSM, the index counter, the overrun flag, and the write-enable decoder. The decoder is a 3-to-8 one-hot, the inverse of the transmitter's select.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → a..h=0, index=0, in_ready=1, out_valid=0, overrun=0.
- Full frame: send 5555, AAAA, 00FF, FF00, 3333, CCCC, 0F0F, F0F0 back-to-back with out_ready=0 → after the 8th edge, out_valid=1 and a..h equal those words in order; index=0 and in_ready=0.
- Release and bubble: from the full-frame state, pulse out_ready for one cycle → next cycle out_valid=0 and in_ready=1. Send 1234 → a=1234 while b..h keep AAAA…F0F0, and index=1.
- Overrun: in HOLD, drive in_valid=1 with in=BEEF for one cycle → overrun=1 and the lanes are unchanged. It stays 1 through the next frame until clear.
- clear mid-frame: after 3 accepted words, assert clear together with in_valid (in=DEAD) → index=0, a..c retain their values, DEAD is not written, and in_ready=1.
- Async reset mid-frame: after 5 accepted words, drop rst_n between clock edges → a..h=0 and index=0 immediately, without waiting for a clk edge.
